// File: rtl/life_board_store_if.sv
// Bundle of control, edit and board signals between the Life board store and its neighbours.
// Signal directions are named from the store's point of view (i_ into the store, o_ out of it).
interface life_board_store_if #(
    parameter int X     = 8,
    parameter int Y     = 8,
    parameter int LOG2X = 3,
    parameter int LOG2Y = 3,
    parameter int LANES = 1,
    parameter int GEN_W = 16
);
    logic               i_run_tgl;
    logic               i_step;
    logic               i_clr_all;
    logic [1:0]         i_edit_op;
    logic [LOG2X-1:0]   i_cursor_x;
    logic [LOG2Y-1:0]   i_cursor_y;
    logic [LANES-1:0]   i_pipe_out;
    logic [X*Y-1:0]     o_board;
    logic [LANES-1:0]   o_cells_out;
    logic               o_adv;
    logic               o_running;
    logic               o_gen_end;
    logic [GEN_W-1:0]   o_gen_cnt;

    modport master (
        output i_run_tgl, i_step, i_clr_all, i_edit_op, i_cursor_x, i_cursor_y, i_pipe_out,
        input  o_board, o_cells_out, o_adv, o_running, o_gen_end, o_gen_cnt
    );

    modport slave (
        input  i_run_tgl, i_step, i_clr_all, i_edit_op, i_cursor_x, i_cursor_y, i_pipe_out,
        output o_board, o_cells_out, o_adv, o_running, o_gen_end, o_gen_cnt
    );
endinterface

// File: rtl/life_board_store.sv
// Game of Life board held as a circular shift register: rotates LANES cells per clock during a
// generation, writes pipeline results back at WB_POS, and accepts cursor edits while idle.
module life_board_store #(
    parameter int X      = 8,
    parameter int Y      = 8,
    parameter int LOG2X  = 3,
    parameter int LOG2Y  = 3,
    parameter int LANES  = 1,
    parameter int WB_POS = (Y-1)*X-3,
    parameter int GEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    life_board_store_if.slave bus
);
    localparam int N    = X*Y;
    localparam int NPOS = N/LANES;
    localparam int PW   = (NPOS > 1) ? $clog2(NPOS) : 1;
    localparam int IW   = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_STEP = 2'd2} state_t;

    state_t           r_state;
    logic [PW-1:0]    r_pos;
    logic             r_stop_req;
    logic [1:0]       r_op_d;
    logic [N-1:0]     r_board;
    logic [GEN_W-1:0] r_gen_cnt;

    logic [N-1:0]     w_board_next;
    logic [N-1:0]     w_rot;
    logic [N-1:0]     w_mask;
    logic [IW-1:0]    w_idx;
    logic             w_idle;
    logic             w_adv;
    logic             w_gen_end;
    logic             w_release;
    logic             w_in_range;
    logic             w_stop;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_adv      = !w_idle;
    assign w_gen_end  = w_adv && (r_pos == PW'(NPOS-1));
    assign w_release  = w_idle && (r_op_d != 2'b00) && (bus.i_edit_op == 2'b00);
    assign w_in_range = (32'(bus.i_cursor_x) < X) && (32'(bus.i_cursor_y) < Y);
    // Row-major index through a real multiply so non power-of-two widths stay correct
    assign w_idx      = IW'(32'(bus.i_cursor_y) * X + 32'(bus.i_cursor_x));
    assign w_mask     = N'(1) << w_idx;
    // A run_tgl on the boundary cycle counts toward the stop decision
    assign w_stop     = r_stop_req ^ bus.i_run_tgl;

    always_comb begin
        w_rot = {r_board[LANES-1:0], r_board[N-1:LANES]};
        w_rot[WB_POS +: LANES] = bus.i_pipe_out;
        w_board_next = r_board;
        if (w_adv) begin
            w_board_next = w_rot;
        end else if (bus.i_clr_all) begin
            w_board_next = '0;
        end else if (w_release && w_in_range) begin
            case (r_op_d)
                2'b01:   w_board_next = r_board ^ w_mask;
                2'b10:   w_board_next = r_board | w_mask;
                2'b11:   w_board_next = r_board & ~w_mask;
                default: w_board_next = r_board;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_pos      <= '0;
            r_stop_req <= 1'b0;
            r_op_d     <= 2'b00;
            r_board    <= '0;
            r_gen_cnt  <= '0;
        end else begin
            r_op_d  <= bus.i_edit_op;
            r_board <= w_board_next;
            if (w_adv) begin
                r_pos <= w_gen_end ? '0 : r_pos + PW'(1);
            end
            if (w_gen_end) begin
                r_gen_cnt <= r_gen_cnt + GEN_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    r_stop_req <= 1'b0;
                    if (bus.i_run_tgl) begin
                        r_state <= ST_RUN;
                    end else if (bus.i_step) begin
                        r_state <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (w_gen_end && w_stop) begin
                        r_state    <= ST_IDLE;
                        r_stop_req <= 1'b0;
                    end else begin
                        r_stop_req <= w_stop;
                    end
                end
                ST_STEP: begin
                    if (w_gen_end) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_board     = r_board;
    assign bus.o_cells_out = r_board[LANES-1:0];
    assign bus.o_adv       = w_adv;
    assign bus.o_running   = w_adv;
    assign bus.o_gen_end   = w_gen_end;
    assign bus.o_gen_cnt   = r_gen_cnt;
endmodule
